// File: rtl/fifo_rd_packer.sv
// Packs RATIO show-ahead FIFO entries (lane 0 = first pop) into one word; FIFO_PACKER_FLUSH_EN adds timed partial flush.
// Latency: m_valid rises on the edge of the RATIO-th pop (or FLUSH_TIMEOUT idle cycles after the last pop when flushing).
// Backpressure: word held stable while m_ready is low; no pops from word-complete until one cycle after accept.
module fifo_rd_packer #(
  parameter int WIDTH         = 8,
  parameter int RATIO         = 4,
  parameter int FLUSH_TIMEOUT = 16,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                   rd_clk,
  input  logic                   asynchronous_rst_n,
  input  logic [WIDTH-1:0]       fifo_data,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  output logic [WIDTH*RATIO-1:0] m_data,
  output logic [RATIO-1:0]       m_keep,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [CNT_WIDTH-1:0]   word_count
);

  localparam int LW = (RATIO > 1) ? $clog2(RATIO) : 1;

  if (RATIO < 2 || FLUSH_TIMEOUT < 1) begin : g_bad_cfg
    $error("fifo_rd_packer: RATIO must be >= 2 and FLUSH_TIMEOUT >= 1");
  end

  typedef enum logic {FILL = 1'b0, SEND = 1'b1} state_t;

  state_t         state, state_nxt;
  logic [LW-1:0]  lane_idx;
  logic           pop;
  logic           last_lane;
  logic           accept;
  logic           flush;

  assign pop        = (state == FILL) && !fifo_empty;
  assign fifo_rd_en = pop && asynchronous_rst_n;
  assign last_lane  = (lane_idx == LW'(RATIO - 1));
  assign accept     = (state == SEND) && m_valid && m_ready;

`ifdef FIFO_PACKER_FLUSH_EN
  localparam int IW = $clog2(FLUSH_TIMEOUT + 1);
  logic [IW-1:0] idle_cnt;
  logic          idle;

  // Counts only while a partial word waits and nothing is popped.
  assign idle  = (state == FILL) && (lane_idx != '0) && !pop;
  assign flush = idle && (idle_cnt == IW'(FLUSH_TIMEOUT - 1));

  always_ff @(posedge rd_clk or negedge asynchronous_rst_n) begin
    if (!asynchronous_rst_n) begin
      idle_cnt <= '0;
    end else if (idle && !flush) begin
      idle_cnt <= idle_cnt + IW'(1);
    end else begin
      idle_cnt <= '0;
    end
  end
`else
  assign flush = 1'b0;
`endif

  always_ff @(posedge rd_clk or negedge asynchronous_rst_n) begin
    if (!asynchronous_rst_n) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL: if ((pop && last_lane) || flush) state_nxt = SEND;
      SEND: if (accept) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge rd_clk or negedge asynchronous_rst_n) begin
    if (!asynchronous_rst_n) begin
      m_data     <= '0;
      m_keep     <= '0;
      m_valid    <= 1'b0;
      word_count <= '0;
      lane_idx   <= '0;
    end else if (accept) begin
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_keep     <= '0;
      word_count <= word_count + CNT_WIDTH'(1);
    end else if (flush) begin
      m_valid  <= 1'b1;
      lane_idx <= '0;
    end else if (pop) begin
      // Full compare per lane so non power-of-two RATIO never aliases.
      for (int i = 0; i < RATIO; i++) begin
        if (lane_idx == LW'(i)) begin
          m_data[i*WIDTH +: WIDTH] <= fifo_data;
          m_keep[i]                <= 1'b1;
        end
      end
      if (last_lane) begin
        lane_idx <= '0;
        m_valid  <= 1'b1;
      end else begin
        lane_idx <= lane_idx + LW'(1);
      end
    end
  end

endmodule
